// File: rtl/driver_pkg.sv
// -----------------------------------------------------------------------------
// driver_pkg
// Shared constants and types for the LED-driver SIN serializer.
//   NB_DRIVERS : number of LED drivers, one SIN line each
//   WORD_W     : bits per driver shift word
//   LAT_LEN_W  : width of the LAT-length field
//   ser_state_t: serializer FSM states
//   drv_word_t : one driver shift word at the default width
// -----------------------------------------------------------------------------
package driver_pkg;

    localparam int NB_DRIVERS = 30;
    localparam int WORD_W     = 48;
    localparam int LAT_LEN_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef logic [WORD_W-1:0] drv_word_t;

endpackage : driver_pkg

// File: rtl/driver_sin_lane.sv
// -----------------------------------------------------------------------------
// driver_sin_lane
// Holds one driver's shift word and selects the bit addressed by the shared
// bit counter. The lane has no control of its own: the top decides when to
// load and which bit is current.
//   clk_i   : system clock
//   load_i  : capture data_i into the word register this cycle
//   data_i  : parallel word for this driver
//   sel_i   : bit index the serializer will present on the next cycle
//   bit_o   : bit sel_i of the word as it will be after this clock edge
// -----------------------------------------------------------------------------
module driver_sin_lane #(
    parameter int WORD_W = 48
) (
    input  logic                      clk_i,
    input  logic                      load_i,
    input  logic [WORD_W-1:0]         data_i,
    input  logic [$clog2(WORD_W)-1:0] sel_i,
    output logic                      bit_o
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = data_i;
        end
    end

    // Data register carries no reset; its content is only observed while
    // the serializer is shifting, which always begins with a load.
    always_ff @(posedge clk_i) begin
        word_q <= word_d;
    end

    // Look ahead at the next-cycle word so the top can register the bit
    // together with the counter and LAT, giving one-clock load latency.
    assign bit_o = word_d[sel_i];

endmodule : driver_sin_lane

// File: rtl/driver_sin_serializer.sv
// -----------------------------------------------------------------------------
// driver_sin_serializer
// Accepts one parallel word per LED driver over a valid/ready handshake and
// shifts all drivers out in lockstep, MSB first, one bit per sclk_en tick.
// LAT is raised over the last lat_len bits of each word; an SCLK gate marks
// every cycle that presents a valid bit. Feeds the SIN remapping LUT.
//   clk           : system clock
//   rst           : synchronous reset, active-high
//   sclk_en       : one-cycle tick, one driver SCLK edge
//   in_data       : driver d word = in_data[d*WORD_W +: WORD_W]
//   in_lat_len    : LAT-high length in bits (0 = no latch, clamped to WORD_W)
//   in_valid      : word available
//   in_ready      : word can be accepted this cycle
//   drv_sin_tolut : current bit of each driver, bit d = driver d
//   drv_lat       : LAT to drivers
//   drv_sclk_gate : high while a valid bit is presented
//   busy          : shifting in progress
// -----------------------------------------------------------------------------
module driver_sin_serializer
    import driver_pkg::*;
#(
    parameter int NB_DRIVERS = driver_pkg::NB_DRIVERS,
    parameter int WORD_W     = driver_pkg::WORD_W,
    parameter int LAT_LEN_W  = driver_pkg::LAT_LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk_en,
    input  logic [NB_DRIVERS*WORD_W-1:0] in_data,
    input  logic [LAT_LEN_W-1:0]         in_lat_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NB_DRIVERS-1:0]        drv_sin_tolut,
    output logic                         drv_lat,
    output logic                         drv_sclk_gate,
    output logic                         busy
);

    localparam int CNT_W = $clog2(WORD_W);
    // lat_len can hold WORD_W itself, so it may need one bit more than CNT_W.
    localparam int LEN_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WORD_W - 1);

    ser_state_t              state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]        lat_len_q, lat_len_d;
    logic [NB_DRIVERS-1:0]   sin_q, sin_d;
    logic                    lat_q, lat_d;
    logic                    gate_q, gate_d;

    logic                    last_tick;
    logic                    load;
    logic [NB_DRIVERS-1:0]   lane_bit;

    function automatic logic [LEN_W-1:0] clamp_lat_len(input logic [LAT_LEN_W-1:0] len);
        if (int'(len) >= WORD_W) begin
            return LEN_W'(WORD_W);
        end
        return LEN_W'(len);
    endfunction

    // The final bit of a word is consumed on this tick; a follow-on word may
    // be taken in the same cycle so the output stream has no bubble.
    assign last_tick = (state_q == SHIFT) && sclk_en && (bit_cnt_q == '0);
    assign in_ready  = !rst && ((state_q == IDLE) || last_tick);
    assign load      = in_valid && in_ready;

    for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_lane
        driver_sin_lane #(
            .WORD_W (WORD_W)
        ) u_lane (
            .clk_i  (clk),
            .load_i (load),
            .data_i (in_data[d*WORD_W +: WORD_W]),
            .sel_i  (bit_cnt_d),
            .bit_o  (lane_bit[d])
        );
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        lat_len_d = lat_len_q;

        if (state_q == IDLE) begin
            if (load) begin
                state_d   = SHIFT;
                bit_cnt_d = CNT_TOP;
                lat_len_d = clamp_lat_len(in_lat_len);
            end
        end else begin
            if (sclk_en) begin
                if (bit_cnt_q == '0) begin
                    // Explicit end-of-word: either reload or return to idle,
                    // the counter never wraps below zero.
                    if (load) begin
                        bit_cnt_d = CNT_TOP;
                        lat_len_d = clamp_lat_len(in_lat_len);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
        end

        // Outputs are derived from next state so SIN, LAT and the gate are
        // registered together and change on the same edge.
        sin_d  = '0;
        lat_d  = 1'b0;
        gate_d = 1'b0;
        if (state_d == SHIFT) begin
            sin_d  = lane_bit;
            lat_d  = (LEN_W'(bit_cnt_d) < lat_len_d);
            gate_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            lat_len_q <= '0;
            sin_q     <= '0;
            lat_q     <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            lat_len_q <= lat_len_d;
            sin_q     <= sin_d;
            lat_q     <= lat_d;
            gate_q    <= gate_d;
        end
    end

    assign drv_sin_tolut = sin_q;
    assign drv_lat       = lat_q;
    assign drv_sclk_gate = gate_q;
    assign busy          = (state_q == SHIFT);

endmodule : driver_sin_serializer

// File: tb/tb_driver_sin_serializer.sv
// -----------------------------------------------------------------------------
// tb_driver_sin_serializer
// Randomised and directed stimulus for driver_sin_serializer, checked every
// cycle against a word-queue reference model: accepted words are queued and
// the model walks a bit index from MSB to LSB on each sclk_en tick.
// -----------------------------------------------------------------------------
module tb_driver_sin_serializer;

    localparam int NB = 30;
    localparam int W  = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              sclk_en;
    logic [NB*W-1:0]   in_data;
    logic [3:0]        in_lat_len;
    logic              in_valid;
    logic              in_ready;
    logic [NB-1:0]     drv_sin_tolut;
    logic              drv_lat;
    logic              drv_sclk_gate;
    logic              busy;

    driver_sin_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .sclk_en       (sclk_en),
        .in_data       (in_data),
        .in_lat_len    (in_lat_len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .drv_sin_tolut (drv_sin_tolut),
        .drv_lat       (drv_lat),
        .drv_sclk_gate (drv_sclk_gate),
        .busy          (busy)
    );

    // Small instance used for the LAT clamp case.
    logic        rst8, sclk8, valid8, ready8, lat8, gate8, busy8;
    logic [15:0] data8;
    logic [3:0]  latlen8;
    logic [1:0]  sin8;

    driver_sin_serializer #(
        .NB_DRIVERS (2),
        .WORD_W     (8),
        .LAT_LEN_W  (4)
    ) dut8 (
        .clk           (clk),
        .rst           (rst8),
        .sclk_en       (sclk8),
        .in_data       (data8),
        .in_lat_len    (latlen8),
        .in_valid      (valid8),
        .in_ready      (ready8),
        .drv_sin_tolut (sin8),
        .drv_lat       (lat8),
        .drv_sclk_gate (gate8),
        .busy          (busy8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of accepted words and the bit index being shown.
    logic [NB*W-1:0] q_data[$];
    int              q_lat[$];
    int              idx;
    bit              hs_seen;
    int              sclk_mode;   // 0 every cycle, 1 every 4th cycle, 2 random
    int              k;
    int              ticks;       // DUT gate-high sclk_en ticks
    int              lat_ticks;   // DUT LAT-high sclk_en ticks
    int              gate_cycles; // DUT gate-high cycles
    int              ready_in_gate;

    task automatic cycle();
        logic [NB-1:0]   exp_sin;
        logic            exp_lat, exp_gate, exp_ready;
        logic [NB*W-1:0] cur;
        int              ll;
        case (sclk_mode)
            0:       sclk_en = 1'b1;
            1:       sclk_en = (k % 4 == 0) && (k > 0);
            default: sclk_en = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        exp_sin  = '0;
        exp_lat  = 1'b0;
        exp_gate = 1'b0;
        if (q_data.size() != 0) begin
            cur = q_data[0];
            for (int d = 0; d < NB; d++) exp_sin[d] = cur[d*W + idx];
            ll       = (q_lat[0] < W) ? q_lat[0] : W;
            exp_lat  = (idx < ll);
            exp_gate = 1'b1;
        end
        exp_ready = !rst && (q_data.size() == 0 || (sclk_en && idx == 0));
        chk("sin",   64'(drv_sin_tolut), 64'(exp_sin));
        chk("lat",   64'(drv_lat),       64'(exp_lat));
        chk("gate",  64'(drv_sclk_gate), 64'(exp_gate));
        chk("busy",  64'(busy),          64'(exp_gate));
        chk("ready", 64'(in_ready),      64'(exp_ready));
        hs_seen = in_valid && exp_ready;
        if (sclk_en && drv_sclk_gate) ticks++;
        if (sclk_en && drv_sclk_gate && drv_lat) lat_ticks++;
        if (drv_sclk_gate) gate_cycles++;
        if (drv_sclk_gate && in_ready) ready_in_gate++;
        if (rst) begin
            q_data.delete();
            q_lat.delete();
            idx = W - 1;
        end else begin
            if (q_data.size() != 0 && sclk_en) begin
                if (idx == 0) begin
                    void'(q_data.pop_front());
                    void'(q_lat.pop_front());
                    idx = W - 1;
                end else begin
                    idx--;
                end
            end
            if (hs_seen) begin
                q_data.push_back(in_data);
                q_lat.push_back(int'(in_lat_len));
            end
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic send(input logic [NB*W-1:0] data, input logic [3:0] len);
        int n;
        in_data    = data;
        in_lat_len = len;
        in_valid   = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!hs_seen && n < 2000);
        if (!hs_seen) chk("handshake_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_data.size() != 0 && n < 5000) begin
            cycle();
            n++;
        end
        if (q_data.size() != 0) chk("drain_timeout", 64'(q_data.size()), 64'(0));
        cycle();
    endtask

    function automatic logic [NB*W-1:0] all_words(input logic [W-1:0] w);
        logic [NB*W-1:0] r;
        for (int d = 0; d < NB; d++) r[d*W +: W] = w;
        return r;
    endfunction

    function automatic logic [NB*W-1:0] rand_words();
        logic [NB*W-1:0] r;
        for (int i = 0; i < NB*W; i += 32) r[i +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        logic [NB*W-1:0] w;
        logic [7:0]      a8, b8;
        int              n;

        rst = 1'b1; sclk_en = 1'b0; in_valid = 1'b0; in_data = '0; in_lat_len = '0;
        rst8 = 1'b1; sclk8 = 1'b1; valid8 = 1'b0; data8 = '0; latlen8 = '0;
        sclk_mode = 0; idx = W - 1; k = 0;
        ticks = 0; lat_ticks = 0; gate_cycles = 0; ready_in_gate = 0;

        // Reset state, including in_ready low while rst is held.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Single word, driver 0 only, no LAT.
        w = '0;
        w[W-1:0] = 48'h8000_0000_0001;
        ticks = 0; lat_ticks = 0;
        send(w, 4'd0);
        drain();
        chk("single_ticks", 64'(ticks), 64'(48));
        chk("single_lat_ticks", 64'(lat_ticks), 64'(0));

        // LAT window over the last three bits.
        ticks = 0; lat_ticks = 0;
        send(all_words(48'hFFFF_0000_FFFF), 4'd3);
        drain();
        chk("latwin_ticks", 64'(ticks), 64'(48));
        chk("latwin_lat_ticks", 64'(lat_ticks), 64'(3));

        // Back-to-back with in_valid held.
        ticks = 0; gate_cycles = 0; ready_in_gate = 0;
        send(all_words(48'hAAAA_AAAA_AAAA), 4'd0);
        send('0, 4'd0);
        drain();
        chk("b2b_ticks", 64'(ticks), 64'(96));
        chk("b2b_gate_cycles", 64'(gate_cycles), 64'(96));
        chk("b2b_ready_pulses", 64'(ready_in_gate), 64'(2));

        // Sparse sclk_en, driver 29 carries 1.
        sclk_mode = 1; k = 0; gate_cycles = 0; ticks = 0;
        w = '0;
        w[29*W +: W] = 48'h1;
        send(w, 4'd0);
        drain();
        chk("sparse_gate_cycles", 64'(gate_cycles), 64'(192));
        chk("sparse_ticks", 64'(ticks), 64'(48));

        // Reset mid-word at bit 20.
        sclk_mode = 0; lat_ticks = 0;
        send(rand_words(), 4'd15);
        n = 0;
        while ((q_data.size() == 0 || idx != 20) && n < 200) begin
            cycle();
            n++;
        end
        chk("rst_reach_bit20", 64'(idx), 64'(20));
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("rst_no_lat", 64'(lat_ticks), 64'(0));

        // Random traffic: random sclk_en, valid, data and lat_len.
        sclk_mode = 2;
        for (int i = 0; i < 800; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = rand_words();
            in_lat_len = 4'($urandom_range(0, 15));
            cycle();
        end
        in_valid = 1'b0;
        drain();

        // LAT clamp on an 8-bit instance.
        a8 = 8'hA5; b8 = 8'h3C;
        repeat (2) @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        chk("w8_ready_idle", 64'(ready8), 64'(1));
        chk("w8_gate_idle", 64'(gate8), 64'(0));
        data8 = {a8, b8}; latlen8 = 4'd15; valid8 = 1'b1;
        @(posedge clk);
        #1 valid8 = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            chk("w8_sin", 64'(sin8), 64'({a8[b], b8[b]}));
            chk("w8_lat", 64'(lat8), 64'(1));
            chk("w8_gate", 64'(gate8), 64'(1));
            chk("w8_busy", 64'(busy8), 64'(1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("w8_gate_end", 64'(gate8), 64'(0));
        chk("w8_lat_end", 64'(lat8), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_driver_sin_serializer
